// File: rtl/serial_ult.sv
`default_nettype none
// ============================================================================
// Module   : serial_ult
// Purpose  : Bit-serial, multi-cycle unsigned less-than / equality comparator.
//            Two width-bit operands are taken in through a valid/ready
//            handshake and scanned one bit per cycle, LSB first. The result
//            (O = I0 < I1, EQ = I0 == I1) is held until the consumer takes it.
// Ports    : CLK          rising-edge clock
//            ASYNCRESETN  asynchronous active-low reset
//            I0, I1       operands, sampled only on the accept edge
//            in_valid     operands present
//            in_ready     block can accept operands (IDLE)
//            O            result A < B (unsigned)
//            EQ           result A == B
//            out_valid    O/EQ valid (DONE)
//            out_ready    consumer takes the result
// Revision : 1.0  initial release
// ============================================================================
module serial_ult #(
  parameter int width = 4
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [width-1:0] I0,
  input  logic [width-1:0] I1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             O,
  output logic             EQ,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int                 c_cnt_w = $clog2(width) + 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(width - 1);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [width-1:0]   r_a;
  logic [width-1:0]   r_b;
  logic               r_lt;
  logic               r_eq;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_o;
  logic               r_eq_out;

  logic w_bit_a;
  logic w_bit_b;
  logic w_diff;
  logic w_lt_next;
  logic w_eq_next;

  // One step of the LSB-first scan: a differing bit decides lt outright,
  // an equal bit carries forward whatever the lower bits decided.
  assign w_bit_a   = r_a[0];
  assign w_bit_b   = r_b[0];
  assign w_diff    = w_bit_a ^ w_bit_b;
  assign w_lt_next = (~w_bit_a & w_bit_b) | (~w_diff & r_lt);
  assign w_eq_next = r_eq & ~w_diff;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_lt     <= 1'b0;
      r_eq     <= 1'b0;
      r_cnt    <= '0;
      r_o      <= 1'b0;
      r_eq_out <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= I0;
            r_b     <= I1;
            r_lt    <= 1'b0;
            r_eq    <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_lt  <= w_lt_next;
          r_eq  <= w_eq_next;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + c_one;
          if (r_cnt == c_last) begin
            // Publish the final step directly so the result is valid on
            // the same edge the state becomes DONE.
            r_o      <= w_lt_next;
            r_eq_out <= w_eq_next;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign O         = r_o;
  assign EQ        = r_eq_out;

endmodule
`default_nettype wire

// File: tb/tb_serial_ult.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_ult
// Purpose  : Self-checking bench for serial_ult at width 1, 4 and 8. Results
//            are compared with a reference built from plain unsigned < / ==.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_ult;

  logic clk;
  logic rst_n;

  logic       i0_1, i1_1, iv_1, ir_1, o_1, eq_1, ov_1, or_1;
  logic [3:0] i0_4, i1_4;
  logic       iv_4, ir_4, o_4, eq_4, ov_4, or_4;
  logic [7:0] i0_8, i1_8;
  logic       iv_8, ir_8, o_8, eq_8, ov_8, or_8;

  int vectors;
  int miscompares;

  serial_ult #(.width(1)) u_dut1 (
    .CLK(clk), .ASYNCRESETN(rst_n), .I0(i0_1), .I1(i1_1),
    .in_valid(iv_1), .in_ready(ir_1), .O(o_1), .EQ(eq_1),
    .out_valid(ov_1), .out_ready(or_1)
  );

  serial_ult #(.width(4)) u_dut4 (
    .CLK(clk), .ASYNCRESETN(rst_n), .I0(i0_4), .I1(i1_4),
    .in_valid(iv_4), .in_ready(ir_4), .O(o_4), .EQ(eq_4),
    .out_valid(ov_4), .out_ready(or_4)
  );

  serial_ult #(.width(8)) u_dut8 (
    .CLK(clk), .ASYNCRESETN(rst_n), .I0(i0_8), .I1(i1_8),
    .in_valid(iv_8), .in_ready(ir_8), .O(o_8), .EQ(eq_8),
    .out_valid(ov_8), .out_ready(or_8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int w, input logic [7:0] a, input logic [7:0] b, input logic v);
    case (w)
      1:       begin i0_1 = a[0];   i1_1 = b[0];   iv_1 = v; end
      4:       begin i0_4 = a[3:0]; i1_4 = b[3:0]; iv_4 = v; end
      default: begin i0_8 = a;      i1_8 = b;      iv_8 = v; end
    endcase
  endtask

  task automatic set_or(input int w, input logic v);
    case (w)
      1:       or_1 = v;
      4:       or_4 = v;
      default: or_8 = v;
    endcase
  endtask

  // {in_ready, out_valid, O, EQ}
  function automatic logic [3:0] get_out(input int w);
    case (w)
      1:       return {ir_1, ov_1, o_1, eq_1};
      4:       return {ir_4, ov_4, o_4, eq_4};
      default: return {ir_8, ov_8, o_8, eq_8};
    endcase
  endfunction

  // One full transaction: accept, measure latency, check result, optionally
  // hold it under backpressure (with ignored in_valid pulses), then consume.
  task automatic do_cmp(input int w, input logic [7:0] a, input logic [7:0] b,
                        input int hold, input string tag);
    logic [7:0] m;
    logic [7:0] am;
    logic [7:0] bm;
    logic       exp_lt;
    logic       exp_eq;
    logic [3:0] outs;
    int         lat;
    bit         seen;
    m      = 8'((9'd1 << w) - 9'd1);
    am     = a & m;
    bm     = b & m;
    exp_lt = (am < bm);
    exp_eq = (am == bm);

    @(negedge clk);
    outs = get_out(w);
    chk({tag, " ready"}, 32'(outs[3]), 32'd1);
    set_or(w, (hold == 0));
    set_in(w, a, b, 1'b1);
    @(posedge clk);
    #1;
    if (hold > 0) set_in(w, 8'd1, 8'd2, 1'b1);
    else          set_in(w, 8'($urandom), 8'($urandom), 1'b0);

    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      outs = get_out(w);
      if (outs[2]) seen = 1'b1;
      else if (outs[3] && hold > 0) chk({tag, " busy_ready"}, 32'(outs[3]), 32'd0);
    end
    chk({tag, " latency"}, 32'(lat), 32'(w));
    chk({tag, " O"},  32'(outs[1]), 32'(exp_lt));
    chk({tag, " EQ"}, 32'(outs[0]), 32'(exp_eq));

    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      outs = get_out(w);
      chk({tag, " hold_valid"}, 32'(outs[2]), 32'd1);
      chk({tag, " hold_ready"}, 32'(outs[3]), 32'd0);
      chk({tag, " hold_O"},  32'(outs[1]), 32'(exp_lt));
      chk({tag, " hold_EQ"}, 32'(outs[0]), 32'(exp_eq));
    end
    set_in(w, 8'($urandom), 8'($urandom), 1'b0);
    set_or(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    outs = get_out(w);
    chk({tag, " drop_valid"}, 32'(outs[2]), 32'd0);
    chk({tag, " idle_ready"}, 32'(outs[3]), 32'd1);
  endtask

  initial begin
    logic [3:0] outs;
    int         w;
    int         ws[3];
    vectors     = 0;
    miscompares = 0;
    ws[0] = 1; ws[1] = 4; ws[2] = 8;
    rst_n = 1'b0;
    set_in(1, 8'd0, 8'd0, 1'b0); set_in(4, 8'd0, 8'd0, 1'b0); set_in(8, 8'd0, 8'd0, 1'b0);
    or_1 = 1'b1; or_4 = 1'b1; or_8 = 1'b1;

    // Reset and idle state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset {rdy,ov,O,EQ}", 32'(get_out(4)), 32'h8);
    chk("reset w1", 32'(get_out(1)), 32'h8);
    chk("reset w8", 32'(get_out(8)), 32'h8);

    // Asynchronous reset while a result is held
    or_4 = 1'b0;
    set_in(4, 8'd7, 8'd7, 1'b1);
    @(posedge clk);
    #1 set_in(4, 8'd0, 8'd0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("async pre ov/EQ", 32'(get_out(4)), 32'h5);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset outs", 32'(get_out(4)), 32'h8);
    @(negedge clk);
    rst_n = 1'b1;
    or_4 = 1'b1;

    // Basic and boundary compares, width 4
    do_cmp(4, 8'd3,  8'd9,  0, "3<9");
    do_cmp(4, 8'd9,  8'd3,  0, "9<3");
    do_cmp(4, 8'd7,  8'd7,  0, "7==7");
    do_cmp(4, 8'h7,  8'h8,  0, "msb");
    do_cmp(4, 8'd15, 8'd0,  0, "15<0");
    do_cmp(4, 8'd0,  8'd15, 0, "0<15");
    do_cmp(4, 8'd0,  8'd0,  0, "0==0");

    // Backpressure with ignored in_valid pulses
    do_cmp(4, 8'd6, 8'd11, 10, "bp");
    repeat (6) begin
      @(negedge clk);
      chk("bp no_extra_result", 32'(get_out(4)), 32'({1'b1, 1'b0, get_out(4)[1:0]}));
    end

    // Reset two cycles into BUSY: no result may emerge
    @(negedge clk);
    set_in(4, 8'd2, 8'd5, 1'b1);
    @(posedge clk);
    #1 set_in(4, 8'd0, 8'd0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int ov_seen;
      ov_seen = 0;
      repeat (8) begin
        @(negedge clk);
        if (get_out(4)[2]) ov_seen++;
      end
      chk("midreset no ov", 32'(ov_seen), 32'd0);
    end
    do_cmp(4, 8'd5, 8'd2, 0, "after_reset");

    // Width 1, all pairs; width 8 directed
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        do_cmp(1, 8'(a), 8'(b), (a + b) % 2, "w1");
    do_cmp(8, 8'd200, 8'd201, 0, "200<201");
    do_cmp(8, 8'd128, 8'd127, 1, "128<127");

    // Randomized sweep across all widths
    for (int n = 0; n < 1000; n++) begin
      w = ws[$urandom_range(0, 2)];
      do_cmp(w, 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global timeout
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
